// File: rtl/parity_pkg.sv
// parity_pkg: state encodings and parity-sense constants shared by the parity tx/rx paths
package parity_pkg;
  typedef enum logic {
    S_DATA   = 1'b0,
    S_PARITY = 1'b1
  } state_t;
  localparam bit EVEN = 1'b0;
  localparam bit ODD  = 1'b1;
endpackage

// File: rtl/parity_out_buf.sv
// parity_out_buf: single-entry ready/valid holding register with overrun pulse
module parity_out_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] d,
  input  logic         e,
  input  logic         ready,
  output logic [W-1:0] data,
  output logic         err,
  output logic         valid,
  output logic         overrun
);
  logic take;
  assign take = load && (!valid || ready);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      data    <= '0;
      err     <= 1'b0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= load && valid && !ready;
      valid   <= take || (valid && !ready);
      if (take) begin
        data <= d;
        err  <= e;
      end
    end
endmodule

// File: rtl/parity_checker_rx.sv
// parity_checker_rx: deserialises LSB-first frames, checks parity, buffers word + error flag
module parity_checker_rx
  import parity_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter bit ODD_PARITY = EVEN
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_bit,
  input  logic                 i_valid,
  input  logic                 i_clear,
  input  logic                 i_ready,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_parity_err,
  output logic                 o_valid,
  output logic                 o_overrun,
  output logic                 o_busy
);
  localparam int CW = DATA_BITS > 1 ? $clog2(DATA_BITS) : 1;
  state_t                state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [DATA_BITS-1:0]  sr, sr_n;
  logic                  acc, acc_n, done, last;
  assign last = cnt == CW'(DATA_BITS - 1);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state <= S_DATA;
      cnt   <= '0;
      sr    <= '0;
      acc   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      sr    <= sr_n;
      acc   <= acc_n;
    end
  // clear wins over a bit arriving in the same cycle; that bit is dropped
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sr_n    = sr;
    acc_n   = acc;
    done    = 1'b0;
    if (i_clear) begin
      state_n = S_DATA;
      cnt_n   = '0;
      sr_n    = '0;
      acc_n   = 1'b0;
    end else if (i_valid && state == S_DATA) begin
      sr_n    = sr | (DATA_BITS'(i_bit) << cnt);
      acc_n   = acc ^ i_bit;
      cnt_n   = last ? '0 : cnt + CW'(1);
      state_n = last ? S_PARITY : S_DATA;
    end else if (i_valid) begin
      done    = 1'b1;
      state_n = S_DATA;
      sr_n    = '0;
      acc_n   = 1'b0;
    end
  end
  assign o_busy = (state == S_PARITY) || (cnt != '0);
  parity_out_buf #(.W(DATA_BITS)) u_buf (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .load   (done),
    .d      (sr),
    .e      (acc ^ i_bit ^ ODD_PARITY),
    .ready  (i_ready),
    .data   (o_data),
    .err    (o_parity_err),
    .valid  (o_valid),
    .overrun(o_overrun)
  );
endmodule

// File: tb/tb_parity_checker_rx.sv
// tb_parity_checker_rx: even and odd instances on one stimulus, checked against a frame-level model
module tb_parity_checker_rx;
  logic clk = 1'b0, rst_n = 1'b0;
  logic sbit = 1'b0, svalid = 1'b0, sclear = 1'b0, sready = 1'b1;
  logic [7:0] data_e, data_o;
  logic err_e, valid_e, over_e, busy_e, err_o, valid_o, over_o, busy_o;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  parity_checker_rx #(.DATA_BITS(8), .ODD_PARITY(1'b0)) dut_e (
    .i_clk(clk), .i_rst_n(rst_n), .i_bit(sbit), .i_valid(svalid), .i_clear(sclear), .i_ready(sready),
    .o_data(data_e), .o_parity_err(err_e), .o_valid(valid_e), .o_overrun(over_e), .o_busy(busy_e));
  parity_checker_rx #(.DATA_BITS(8), .ODD_PARITY(1'b1)) dut_o (
    .i_clk(clk), .i_rst_n(rst_n), .i_bit(sbit), .i_valid(svalid), .i_clear(sclear), .i_ready(sready),
    .o_data(data_o), .o_parity_err(err_o), .o_valid(valid_o), .o_overrun(over_o), .o_busy(busy_o));
  // frame-level model: collected bits in a queue, one buffered word
  bit q[$];
  logic [7:0] m_data = 8'h00, mw;
  logic m_err_e = 1'b0, m_err_o = 1'b0, m_valid = 1'b0, m_over = 1'b0;
  bit mld;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q.delete();
      m_data = 8'h00; m_err_e = 1'b0; m_err_o = 1'b0; m_valid = 1'b0; m_over = 1'b0;
    end else begin
      m_over = 1'b0;
      mld = 1'b0;
      if (sclear) q.delete();
      else if (svalid && q.size() == 8) begin
        for (int i = 0; i < 8; i++) mw[i] = q[i];
        q.delete();
        if (!m_valid || sready) begin
          m_data = mw;
          m_err_e = ($countones(mw) + int'(sbit)) % 2 != 0;
          m_err_o = ($countones(mw) + int'(sbit)) % 2 != 1;
          m_valid = 1'b1;
          mld = 1'b1;
        end else m_over = 1'b1;
      end else if (svalid) q.push_back(sbit);
      if (!mld && m_valid && sready) m_valid = 1'b0;
    end
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", n, a, e, $time);
    end
  endtask
  always @(negedge clk) begin
    chk("data_e", data_e, m_data);
    chk("err_e", err_e, m_err_e);
    chk("valid_e", valid_e, m_valid);
    chk("over_e", over_e, m_over);
    chk("busy_e", busy_e, q.size() != 0);
    chk("data_o", data_o, m_data);
    chk("err_o", err_o, m_err_o);
    chk("valid_o", valid_o, m_valid);
    chk("over_o", over_o, m_over);
    chk("busy_o", busy_o, q.size() != 0);
  end
  task automatic idle(input bit gap);
    svalid = 1'b0;
    if (gap) repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask
  task automatic bitc(input logic b);
    sbit = b;
    svalid = 1'b1;
    @(negedge clk);
    svalid = 1'b0;
  endtask
  task automatic frame(input logic [7:0] w, input logic p, input bit gap);
    for (int i = 0; i < 8; i++) begin
      idle(gap);
      bitc(w[i]);
    end
    idle(gap);
    bitc(p);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_data", data_e, 0);
    chk("rst_valid", valid_e, 0);
    chk("rst_busy", busy_e, 0);
    rst_n = 1'b1;
    @(negedge clk);
    frame(8'hA5, 1'b0, 1'b0);
    chk("a5_data", data_e, 8'hA5);
    chk("a5_valid", valid_e, 1);
    chk("a5_err_even", err_e, 0);
    chk("a5_err_odd", err_o, 1);
    frame(8'hA5, 1'b1, 1'b0);
    chk("a5p1_data", data_e, 8'hA5);
    chk("a5p1_err_even", err_e, 1);
    chk("a5p1_err_odd", err_o, 0);
    @(negedge clk);
    sready = 1'b0;
    frame(8'h0F, 1'b0, 1'b0);
    chk("ov_first", data_e, 8'h0F);
    frame(8'hF0, 1'b0, 1'b0);
    chk("ov_pulse", over_e, 1);
    chk("ov_keep", data_e, 8'h0F);
    @(negedge clk);
    chk("ov_once", over_e, 0);
    chk("ov_hold_valid", valid_e, 1);
    sready = 1'b1;
    @(negedge clk);
    chk("ov_drain", valid_e, 0);
    bitc(1'b1); bitc(1'b0); bitc(1'b1); bitc(1'b1);
    chk("clr_busy_pre", busy_e, 1);
    sclear = 1'b1; sbit = 1'b1; svalid = 1'b1;
    @(negedge clk);
    sclear = 1'b0; svalid = 1'b0;
    chk("clr_busy", busy_e, 0);
    frame(8'h3C, 1'b0, 1'b0);
    chk("clr_data", data_e, 8'h3C);
    chk("clr_err", err_e, 0);
    chk("clr_busy_post", busy_e, 0);
    sready = 1'b0;
    frame(8'h5A, 1'b0, 1'b0);
    bitc(1'b1); bitc(1'b1); bitc(1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_data", data_e, 0);
    chk("arst_valid", valid_e, 0);
    chk("arst_busy", busy_e, 0);
    chk("arst_err_o", err_o, 0);
    chk("arst_over", over_e, 0);
    @(negedge clk);
    rst_n = 1'b1;
    sready = 1'b1;
    frame(8'hA5, 1'b0, 1'b0);
    chk("post_rst_data", data_e, 8'hA5);
    chk("post_rst_err", err_e, 0);
    for (int k = 0; k < 1000; k++) begin
      mw = 8'($urandom);
      frame(mw, 1'($urandom), 1'b1);
    end
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
